// File: rtl/ysyx_22040750_clint_arbiter_pkg.sv
// Shared definitions for the CLINT port arbiter: FSM state encodings and master ids.
package ysyx_22040750_clint_arbiter_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_AW,
    W_W,
    W_B
  } wr_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-way round-robin grant. Under contention the master not granted last time wins;
// last_grant only moves when the caller accepts a grant with take asserted.
module ysyx_22040750_rr_arb2
  import ysyx_22040750_clint_arbiter_pkg::*;
#(
  parameter bit FIRST_GRANT = 1'b1
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

  logic last_grant;

  always_comb begin
    gnt = ~last_grant;
    case (req)
      2'b01:   gnt = M0;
      2'b10:   gnt = M1;
      default: gnt = ~last_grant;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      last_grant <= ~FIRST_GRANT;
    end else if (take && (req != 2'b00)) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/ysyx_22040750_clint_arbiter.sv
// Shares one CLINT slave port between IFU (M0, read-only) and LSU (M1, read/write).
// Reads are round-robin arbitrated with one outstanding; writes are LSU-only, AW -> W -> B.
module ysyx_22040750_clint_arbiter
  import ysyx_22040750_clint_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned FIRST_GRANT = 1
) (
  input  logic                I_clk,
  input  logic                I_rst,
  // M0 (IFU) read
  input  logic                I_m0_arvalid,
  output logic                O_m0_arready,
  input  logic [ADDR_W-1:0]   I_m0_araddr,
  output logic                O_m0_rvalid,
  input  logic                I_m0_rready,
  output logic [DATA_W-1:0]   O_m0_rdata,
  // M1 (LSU) read
  input  logic                I_m1_arvalid,
  output logic                O_m1_arready,
  input  logic [ADDR_W-1:0]   I_m1_araddr,
  output logic                O_m1_rvalid,
  input  logic                I_m1_rready,
  output logic [DATA_W-1:0]   O_m1_rdata,
  // M1 (LSU) write
  input  logic                I_m1_awvalid,
  output logic                O_m1_awready,
  input  logic [ADDR_W-1:0]   I_m1_awaddr,
  input  logic                I_m1_wvalid,
  output logic                O_m1_wready,
  input  logic [DATA_W-1:0]   I_m1_wdata,
  input  logic [DATA_W/8-1:0] I_m1_wstrb,
  output logic                O_m1_bvalid,
  input  logic                I_m1_bready,
  // Slave (CLINT)
  output logic                O_s_arvalid,
  input  logic                I_s_arready,
  output logic [ADDR_W-1:0]   O_s_araddr,
  input  logic                I_s_rvalid,
  output logic                O_s_rready,
  input  logic [DATA_W-1:0]   I_s_rdata,
  output logic                O_s_awvalid,
  input  logic                I_s_awready,
  output logic [ADDR_W-1:0]   O_s_awaddr,
  output logic                O_s_wvalid,
  input  logic                I_s_wready,
  output logic [DATA_W-1:0]   O_s_wdata,
  output logic [DATA_W/8-1:0] O_s_wstrb,
  input  logic                I_s_bvalid,
  output logic                O_s_bready
);

  rd_state_e rd_q;
  wr_state_e wr_q;
  logic      gnt_q;
  logic      b_pend_q;
  logic      arb_gnt;

  ysyx_22040750_rr_arb2 #(
    .FIRST_GRANT (FIRST_GRANT[0])
  ) u_rr_arb2 (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .req   ({I_m1_arvalid, I_m0_arvalid}),
    .take  (rd_q == R_IDLE),
    .gnt   (arb_gnt)
  );

  // Read channel
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rd_q  <= R_IDLE;
      gnt_q <= M0;
    end else begin
      case (rd_q)
        R_IDLE: begin
          if (I_m0_arvalid || I_m1_arvalid) begin
            gnt_q <= arb_gnt;
            rd_q  <= R_AR;
          end
        end
        R_AR:    if (O_s_arvalid && I_s_arready) rd_q <= R_R;
        R_R:     if (I_s_rvalid && O_s_rready) rd_q <= R_IDLE;
        default: rd_q <= R_IDLE;
      endcase
    end
  end

  assign O_s_araddr = (gnt_q == M1) ? I_m1_araddr : I_m0_araddr;
  assign O_m0_rdata = I_s_rdata;
  assign O_m1_rdata = I_s_rdata;

  always_comb begin
    O_s_arvalid  = 1'b0;
    O_s_rready   = 1'b0;
    O_m0_arready = 1'b0;
    O_m1_arready = 1'b0;
    O_m0_rvalid  = 1'b0;
    O_m1_rvalid  = 1'b0;
    case (rd_q)
      R_AR: begin
        O_s_arvalid  = (gnt_q == M1) ? I_m1_arvalid : I_m0_arvalid;
        O_m0_arready = (gnt_q == M0) && I_s_arready;
        O_m1_arready = (gnt_q == M1) && I_s_arready;
      end
      R_R: begin
        O_s_rready  = (gnt_q == M1) ? I_m1_rready : I_m0_rready;
        O_m0_rvalid = (gnt_q == M0) && I_s_rvalid;
        O_m1_rvalid = (gnt_q == M1) && I_s_rvalid;
      end
      default: ;
    endcase
  end

  // Write channel; b_pend catches a single-cycle slave B pulse until M1 takes it
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_q     <= W_IDLE;
      b_pend_q <= 1'b0;
    end else begin
      case (wr_q)
        W_IDLE: if (I_m1_awvalid) wr_q <= W_AW;
        W_AW:   if (I_m1_awvalid && I_s_awready) wr_q <= W_W;
        W_W: begin
          if (I_m1_wvalid && I_s_wready) begin
            wr_q <= W_B;
            if (I_s_bvalid) b_pend_q <= 1'b1;
          end
        end
        W_B: begin
          if (I_s_bvalid) b_pend_q <= 1'b1;
          if (b_pend_q && I_m1_bready) begin
            wr_q     <= W_IDLE;
            b_pend_q <= 1'b0;
          end
        end
        default: wr_q <= W_IDLE;
      endcase
    end
  end

  assign O_s_awaddr = I_m1_awaddr;
  assign O_s_wdata  = I_m1_wdata;
  assign O_s_wstrb  = I_m1_wstrb;

  always_comb begin
    O_s_awvalid  = 1'b0;
    O_s_wvalid   = 1'b0;
    O_s_bready   = 1'b0;
    O_m1_awready = 1'b0;
    O_m1_wready  = 1'b0;
    O_m1_bvalid  = 1'b0;
    case (wr_q)
      W_AW: begin
        O_s_awvalid  = I_m1_awvalid;
        O_m1_awready = I_s_awready;
      end
      W_W: begin
        O_s_wvalid  = I_m1_wvalid;
        O_m1_wready = I_s_wready;
      end
      W_B: begin
        O_s_bready  = !b_pend_q;
        O_m1_bvalid = b_pend_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040750_clint_arbiter.sv
// Directed and randomized bench for the CLINT arbiter; slave and masters are driven from tasks.
module tb_ysyx_22040750_clint_arbiter;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_m0_arvalid, O_m0_arready, O_m0_rvalid, I_m0_rready;
  logic [31:0] I_m0_araddr;
  logic [63:0] O_m0_rdata;
  logic        I_m1_arvalid, O_m1_arready, O_m1_rvalid, I_m1_rready;
  logic [31:0] I_m1_araddr;
  logic [63:0] O_m1_rdata;
  logic        I_m1_awvalid, O_m1_awready, I_m1_wvalid, O_m1_wready, O_m1_bvalid, I_m1_bready;
  logic [31:0] I_m1_awaddr;
  logic [63:0] I_m1_wdata;
  logic [7:0]  I_m1_wstrb;
  logic        O_s_arvalid, I_s_arready, I_s_rvalid, O_s_rready;
  logic [31:0] O_s_araddr;
  logic [63:0] I_s_rdata;
  logic        O_s_awvalid, I_s_awready, O_s_wvalid, I_s_wready, I_s_bvalid, O_s_bready;
  logic [31:0] O_s_awaddr;
  logic [63:0] O_s_wdata;
  logic [7:0]  O_s_wstrb;

  int n_cmp = 0;
  int n_err = 0;
  int last_served;  // model: master served most recently; 0 after reset so M1 wins first

  always #5 I_clk = ~I_clk;

  ysyx_22040750_clint_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (64),
    .FIRST_GRANT (1)
  ) dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_m0_arvalid (I_m0_arvalid),
    .O_m0_arready (O_m0_arready),
    .I_m0_araddr  (I_m0_araddr),
    .O_m0_rvalid  (O_m0_rvalid),
    .I_m0_rready  (I_m0_rready),
    .O_m0_rdata   (O_m0_rdata),
    .I_m1_arvalid (I_m1_arvalid),
    .O_m1_arready (O_m1_arready),
    .I_m1_araddr  (I_m1_araddr),
    .O_m1_rvalid  (O_m1_rvalid),
    .I_m1_rready  (I_m1_rready),
    .O_m1_rdata   (O_m1_rdata),
    .I_m1_awvalid (I_m1_awvalid),
    .O_m1_awready (O_m1_awready),
    .I_m1_awaddr  (I_m1_awaddr),
    .I_m1_wvalid  (I_m1_wvalid),
    .O_m1_wready  (O_m1_wready),
    .I_m1_wdata   (I_m1_wdata),
    .I_m1_wstrb   (I_m1_wstrb),
    .O_m1_bvalid  (O_m1_bvalid),
    .I_m1_bready  (I_m1_bready),
    .O_s_arvalid  (O_s_arvalid),
    .I_s_arready  (I_s_arready),
    .O_s_araddr   (O_s_araddr),
    .I_s_rvalid   (I_s_rvalid),
    .O_s_rready   (O_s_rready),
    .I_s_rdata    (I_s_rdata),
    .O_s_awvalid  (O_s_awvalid),
    .I_s_awready  (I_s_awready),
    .O_s_awaddr   (O_s_awaddr),
    .O_s_wvalid   (O_s_wvalid),
    .I_s_wready   (I_s_wready),
    .O_s_wdata    (O_s_wdata),
    .O_s_wstrb    (O_s_wstrb),
    .I_s_bvalid   (I_s_bvalid),
    .O_s_bready   (O_s_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  function automatic logic [11:0] hs_outs();
    return {O_m0_arready, O_m0_rvalid, O_m1_arready, O_m1_rvalid, O_m1_awready, O_m1_wready,
            O_m1_bvalid, O_s_arvalid, O_s_rready, O_s_awvalid, O_s_wvalid, O_s_bready};
  endfunction

  task automatic clear_inputs();
    I_m0_arvalid = 0; I_m0_araddr = '0; I_m0_rready = 0;
    I_m1_arvalid = 0; I_m1_araddr = '0; I_m1_rready = 0;
    I_m1_awvalid = 0; I_m1_awaddr = '0; I_m1_wvalid = 0; I_m1_wdata = '0; I_m1_wstrb = '0;
    I_m1_bready = 0;
    I_s_arready = 0; I_s_rvalid = 0; I_s_rdata = '0;
    I_s_awready = 0; I_s_wready = 0; I_s_bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    I_rst = 1;
    tick();
    tick();
    I_rst = 0;
    last_served = 0;
  endtask

  // Serves one read for whichever master(s) currently request; the model picks the winner.
  task automatic serve_read(input logic [63:0] data);
    int          exp_m;
    int          n;
    logic [31:0] exp_addr;
    if (I_m0_arvalid && I_m1_arvalid) exp_m = 1 - last_served;
    else if (I_m1_arvalid)            exp_m = 1;
    else                              exp_m = 0;
    last_served = exp_m;
    exp_addr = (exp_m == 1) ? I_m1_araddr : I_m0_araddr;
    #3;
    chk("rd_idle_s_arvalid", O_s_arvalid, 0);
    chk("rd_idle_arready", {O_m0_arready, O_m1_arready}, 0);
    tick();
    n = $urandom_range(0, 2);
    for (int i = 0; i <= n; i++) begin
      I_s_arready = (i == n);
      #3;
      chk("rd_s_arvalid", O_s_arvalid, 1);
      chk("rd_s_araddr", O_s_araddr, exp_addr);
      chk("rd_m0_arready", O_m0_arready, (exp_m == 0) && (i == n));
      chk("rd_m1_arready", O_m1_arready, (exp_m == 1) && (i == n));
      tick();
    end
    I_s_arready = 0;
    if (exp_m == 1) begin I_m1_arvalid = 0; I_m1_rready = 1; end
    else            begin I_m0_arvalid = 0; I_m0_rready = 1; end
    n = $urandom_range(0, 2);
    for (int i = 0; i <= n; i++) begin
      I_s_rvalid = (i == n);
      I_s_rdata  = (i == n) ? data : {$urandom, $urandom};
      #3;
      chk("rd_s_rready", O_s_rready, 1);
      chk("rd_s_arvalid_in_r", O_s_arvalid, 0);
      chk("rd_m0_rvalid", O_m0_rvalid, (exp_m == 0) && (i == n));
      chk("rd_m1_rvalid", O_m1_rvalid, (exp_m == 1) && (i == n));
      if (i == n) chk("rd_rdata", (exp_m == 1) ? O_m1_rdata : O_m0_rdata, data);
      tick();
    end
    I_s_rvalid  = 0;
    I_m0_rready = 0;
    I_m1_rready = 0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input bit early_w, input bit b_in_w, input int b_hold);
    int n;
    I_m1_awvalid = 1;
    I_m1_awaddr  = addr;
    I_s_awready  = 1;
    #3;
    chk("wr_idle_awready", O_m1_awready, 0);
    chk("wr_idle_s_awvalid", O_s_awvalid, 0);
    tick();
    n = early_w ? 2 : $urandom_range(0, 2);
    for (int i = 0; i <= n; i++) begin
      I_s_awready = (i == n);
      I_s_wready  = 1;
      I_m1_wvalid = early_w;
      I_m1_wdata  = data;
      I_m1_wstrb  = strb;
      #3;
      chk("wr_s_awvalid", O_s_awvalid, 1);
      chk("wr_s_awaddr", O_s_awaddr, addr);
      chk("wr_m1_awready", O_m1_awready, i == n);
      chk("wr_aw_s_wvalid", O_s_wvalid, 0);
      chk("wr_aw_m1_wready", O_m1_wready, 0);
      tick();
    end
    I_m1_awvalid = 0;
    I_s_awready  = 0;
    I_m1_wvalid  = 1;
    n = $urandom_range(0, 2);
    for (int i = 0; i <= n; i++) begin
      I_s_wready = (i == n);
      I_s_bvalid = b_in_w && (i == n);
      #3;
      chk("wr_s_wvalid", O_s_wvalid, 1);
      chk("wr_s_wdata", O_s_wdata, data);
      chk("wr_s_wstrb", O_s_wstrb, strb);
      chk("wr_m1_wready", O_m1_wready, i == n);
      chk("wr_w_awready", O_m1_awready, 0);
      tick();
    end
    I_m1_wvalid = 0;
    I_s_wready  = 0;
    I_s_bvalid  = 0;
    if (!b_in_w) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i <= n; i++) begin
        I_s_bvalid = (i == n);
        #3;
        chk("wr_s_bready_wait", O_s_bready, 1);
        chk("wr_m1_bvalid_wait", O_m1_bvalid, 0);
        tick();
      end
      I_s_bvalid = 0;
    end
    for (int i = 0; i <= b_hold; i++) begin
      I_m1_bready = (i == b_hold);
      #3;
      chk("wr_m1_bvalid_held", O_m1_bvalid, 1);
      chk("wr_s_bready_pend", O_s_bready, 0);
      tick();
    end
    I_m1_bready = 0;
    #3;
    chk("wr_bvalid_cleared", O_m1_bvalid, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #3;
    chk("reset_outs", hs_outs(), 0);
    tick();

    // M1 read alone
    I_m1_arvalid = 1;
    I_m1_araddr  = 32'h0200_BFF8;
    serve_read(64'h1234);

    // Back-to-back contention: both masters re-request immediately
    do_reset();
    I_m0_arvalid = 1; I_m0_araddr = $urandom;
    I_m1_arvalid = 1; I_m1_araddr = $urandom;
    for (int k = 0; k < 4; k++) begin
      chk("order", 64'(1 - last_served), (k % 2 == 0) ? 1 : 0);
      serve_read({$urandom, $urandom});
      if (last_served == 1) begin I_m1_arvalid = 1; I_m1_araddr = $urandom; end
      else                  begin I_m0_arvalid = 1; I_m0_araddr = $urandom; end
    end
    I_m0_arvalid = 0;
    I_m1_arvalid = 0;
    tick();

    // Write with B pulsed in W cycle and M1 holding bready low for 3 cycles
    do_write(32'h0200_4000, 64'h64, 8'hFF, 1'b0, 1'b1, 3);
    // W raised before AW is accepted
    do_write($urandom, {$urandom, $urandom}, 8'($urandom), 1'b1, 1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      do_write($urandom, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 2));
    end

    // Random single-master reads
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin I_m1_arvalid = 1; I_m1_araddr = $urandom; end
      else                           begin I_m0_arvalid = 1; I_m0_araddr = $urandom; end
      serve_read({$urandom, $urandom});
    end

    // Concurrent read and write from M1
    I_m1_arvalid = 1;
    I_m1_araddr  = $urandom;
    fork
      serve_read({$urandom, $urandom});
      do_write($urandom, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b0, 1);
    join
    tick();

    // Reset while reading (R_R) and awaiting B (W_B)
    I_m1_arvalid = 1; I_m1_araddr = $urandom;
    I_m1_awvalid = 1; I_m1_awaddr = $urandom;
    tick();
    I_s_arready = 1; I_s_awready = 1;
    tick();
    I_m1_arvalid = 0; I_m1_awvalid = 0; I_s_arready = 0; I_s_awready = 0;
    I_m1_wvalid = 1; I_s_wready = 1;
    tick();
    I_m1_wvalid = 0; I_s_wready = 0; I_m1_rready = 1;
    #3;
    chk("pre_rst_s_rready", O_s_rready, 1);
    chk("pre_rst_s_bready", O_s_bready, 1);
    I_rst = 1;
    tick();
    I_m0_arvalid = 1; I_m1_arvalid = 1; I_m1_awvalid = 1; I_m1_wvalid = 1;
    I_m0_rready = 1; I_m1_bready = 1;
    I_s_arready = 1; I_s_rvalid = 1; I_s_awready = 1; I_s_wready = 1; I_s_bvalid = 1;
    #3;
    chk("mid_rst_outs", hs_outs(), 0);
    tick();
    clear_inputs();
    I_rst = 0;
    last_served = 0;
    I_m0_arvalid = 1; I_m0_araddr = $urandom;
    I_m1_arvalid = 1; I_m1_araddr = $urandom;
    chk("post_rst_pick", 64'(1 - last_served), 1);
    serve_read({$urandom, $urandom});
    chk("post_rst_served_m1", 64'(last_served), 1);
    I_m0_arvalid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
